// File: rtl/fft4_cmul_seq.sv
// Complex multiply sequencer: y = a * w using one shared 12x12 multiplier (four real
// products in turn), with round-half-up, arithmetic shift and 12-bit saturation.
module fft4_cmul_seq #(
    parameter int SHIFT       = 11,
    parameter int MUL_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] a_re,
    input  logic [11:0] a_im,
    input  logic [11:0] w_re,
    input  logic [11:0] w_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] y_re,
    output logic [11:0] y_im,
    output logic        ovf,
    output logic        err,
    output logic        mul_en,
    output logic [11:0] mul_a,
    output logic [11:0] mul_b,
    input  logic [23:0] mul_result,
    input  logic        mul_rdy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ROUND = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic signed [25:0] RND      = 26'sd1 <<< (SHIFT - 1);
    localparam logic        [7:0]  TMO_LAST = 8'(MUL_TIMEOUT - 1);

    // Returns {clamped, value}: rounds, shifts and saturates an accumulator to 12 bits.
    function automatic logic [12:0] round_sat(input logic signed [24:0] acc);
        logic signed [25:0] sum;
        logic signed [25:0] sh;
        sum = 26'($signed({acc[24], acc})) + RND;
        sh  = sum >>> SHIFT;
        if (sh > 26'sd2047) begin
            return {1'b1, 12'h7FF};
        end else if (sh < -26'sd2048) begin
            return {1'b1, 12'h800};
        end else begin
            return {1'b0, sh[11:0]};
        end
    endfunction

    state_t             state_q;
    logic [11:0]        a_re_q, a_im_q, w_re_q, w_im_q;
    logic signed [24:0] acc_re_q, acc_im_q;
    logic [1:0]         step_q;
    logic [7:0]         tmo_q;
    logic               out_valid_q, ovf_q, err_q, mul_en_q;
    logic [11:0]        y_re_q, y_im_q, mul_a_q, mul_b_q;

    logic signed [24:0] prod_d;
    logic [11:0]        op_a_d, op_b_d;
    logic [12:0]        rnd_re_d, rnd_im_d;

    // Sign-extended product, operands for the following step, and rounded results.
    always_comb begin
        prod_d   = $signed({mul_result[23], mul_result});
        rnd_re_d = round_sat(acc_re_q);
        rnd_im_d = round_sat(acc_im_q);
        op_a_d   = a_re_q;
        op_b_d   = w_re_q;
        case (step_q)
            2'd0:    begin op_a_d = a_im_q; op_b_d = w_im_q; end
            2'd1:    begin op_a_d = a_re_q; op_b_d = w_im_q; end
            2'd2:    begin op_a_d = a_im_q; op_b_d = w_re_q; end
            default: begin op_a_d = a_re_q; op_b_d = w_re_q; end
        endcase
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_re_q      <= 12'd0;
            a_im_q      <= 12'd0;
            w_re_q      <= 12'd0;
            w_im_q      <= 12'd0;
            acc_re_q    <= 25'sd0;
            acc_im_q    <= 25'sd0;
            step_q      <= 2'd0;
            tmo_q       <= 8'd0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            mul_en_q    <= 1'b0;
            y_re_q      <= 12'd0;
            y_im_q      <= 12'd0;
            mul_a_q     <= 12'd0;
            mul_b_q     <= 12'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_re_q   <= a_re;
                        a_im_q   <= a_im;
                        w_re_q   <= w_re;
                        w_im_q   <= w_im;
                        acc_re_q <= 25'sd0;
                        acc_im_q <= 25'sd0;
                        step_q   <= 2'd0;
                        mul_a_q  <= a_re;
                        mul_b_q  <= w_re;
                        mul_en_q <= 1'b1;
                        ovf_q    <= 1'b0;
                        err_q    <= 1'b0;
                        state_q  <= ISSUE;
                    end else begin
                        mul_en_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    mul_en_q <= 1'b0;
                    tmo_q    <= 8'd0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (mul_rdy) begin
                        case (step_q)
                            2'd0:    acc_re_q <= acc_re_q + prod_d;
                            2'd1:    acc_re_q <= acc_re_q - prod_d;
                            default: acc_im_q <= acc_im_q + prod_d;
                        endcase
                        step_q <= step_q + 2'd1;
                        if (step_q == 2'd3) begin
                            state_q <= ROUND;
                        end else begin
                            mul_a_q  <= op_a_d;
                            mul_b_q  <= op_b_d;
                            mul_en_q <= 1'b1;
                            state_q  <= ISSUE;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        // Abandon the transaction: report an error with a zero result.
                        err_q       <= 1'b1;
                        ovf_q       <= 1'b0;
                        y_re_q      <= 12'd0;
                        y_im_q      <= 12'd0;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                ROUND: begin
                    y_re_q      <= rnd_re_d[11:0];
                    y_im_q      <= rnd_im_d[11:0];
                    ovf_q       <= rnd_re_d[12] | rnd_im_d[12];
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    mul_en_q    <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign y_re      = y_re_q;
    assign y_im      = y_im_q;
    assign ovf       = ovf_q;
    assign err       = err_q;
    assign mul_en    = mul_en_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule
